// File: rtl/sc_lane_speed_gen.sv
// ============================================================================
// Module   : sc_lane_speed_gen
// Brief    : Multi-lane programmable tick generator with a global level shift.
//            Each lane has its own period. Pause, restart and enable controls
//            let the game FSM freeze, resynchronise or mute lanes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_lane_speed_gen #(
  parameter int LANES       = 4,
  parameter int CNT_WIDTH   = 26,
  parameter int LEVEL_WIDTH = 3,
  parameter int DEF_PERIOD  = 25000000
) (
  input  logic                                      SC_VEL_CLOCK_50,
  input  logic                                      SC_VEL_RESET,
  input  logic                                      run_in,
  input  logic                                      restart_in,
  input  logic [LANES-1:0]                          lane_en_in,
  input  logic [LEVEL_WIDTH-1:0]                    level_in,
  input  logic                                      cfg_we_in,
  input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] cfg_lane_in,
  input  logic [CNT_WIDTH-1:0]                      cfg_period_in,
  output logic [LANES-1:0]                          tick_out,
  output logic                                      all_tick_out
);

  localparam int                   SEL_WIDTH = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_WIDTH-1:0] DEF_VAL   = CNT_WIDTH'(DEF_PERIOD);
  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);

  logic             cfg_valid;
  logic [LANES-1:0] tick_next;
  logic             all_next;

  // Indices beyond the last lane never match any lane.
  assign cfg_valid = cfg_we_in && (32'(cfg_lane_in) < 32'(LANES));

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [SEL_WIDTH-1:0] IDX = SEL_WIDTH'(i);

    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nx;
    logic [CNT_WIDTH-1:0] shifted;
    logic [CNT_WIDTH-1:0] eff;
    logic                 wr_hit;
    logic                 tick_nx;

    assign wr_hit  = cfg_valid && (cfg_lane_in == IDX);
    assign shifted = period >> level_in;
    // A running lane never drops to a zero period, however high the level.
    assign eff     = ((period != '0) && (shifted == '0)) ? ONE : shifted;

    always_comb begin
      cnt_nx  = cnt;
      tick_nx = 1'b0;
      if (restart_in || wr_hit) begin
        cnt_nx = '0;
      end else if (run_in && lane_en_in[i]) begin
        if (period == '0) begin
          cnt_nx = '0;
        end else if (cnt >= eff - ONE) begin
          cnt_nx  = '0;
          tick_nx = 1'b1;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
    end

    always_ff @(posedge SC_VEL_CLOCK_50 or posedge SC_VEL_RESET) begin
      if (SC_VEL_RESET) begin
        period <= DEF_VAL;
        cnt    <= '0;
      end else begin
        if (wr_hit) begin
          period <= cfg_period_in;
        end
        cnt <= cnt_nx;
      end
    end

    assign tick_next[i] = tick_nx;
  end : g_lane

  assign all_next = (|lane_en_in) && (&(tick_next | ~lane_en_in));

  always_ff @(posedge SC_VEL_CLOCK_50 or posedge SC_VEL_RESET) begin
    if (SC_VEL_RESET) begin
      tick_out     <= '0;
      all_tick_out <= 1'b0;
    end else begin
      tick_out     <= tick_next;
      all_tick_out <= all_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sc_lane_speed_gen.sv
// ============================================================================
// Module   : tb_sc_lane_speed_gen
// Brief    : Directed and randomized checks of sc_lane_speed_gen against an
//            elapsed-cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sc_lane_speed_gen;

  localparam int LANES = 4;
  localparam int CW    = 8;
  localparam int LW    = 3;
  localparam int DEF   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             run, restart, cfg_we, all_tick;
  logic [LANES-1:0] en, tick;
  logic [LW-1:0]    level;
  logic [1:0]       cfg_lane;
  logic [CW-1:0]    cfg_period;

  // Second instance with a non-power-of-two lane count for out-of-range writes.
  logic          run_b, restart_b, we_b, all_b;
  logic [4:0]    en_b, tick_b;
  logic [LW-1:0] level_b;
  logic [2:0]    lane_b;
  logic [CW-1:0] per_b;

  sc_lane_speed_gen #(.LANES(LANES), .CNT_WIDTH(CW), .LEVEL_WIDTH(LW), .DEF_PERIOD(DEF)) dut (
    .SC_VEL_CLOCK_50(clk), .SC_VEL_RESET(rst), .run_in(run), .restart_in(restart),
    .lane_en_in(en), .level_in(level), .cfg_we_in(cfg_we), .cfg_lane_in(cfg_lane),
    .cfg_period_in(cfg_period), .tick_out(tick), .all_tick_out(all_tick));

  sc_lane_speed_gen #(.LANES(5), .CNT_WIDTH(CW), .LEVEL_WIDTH(LW), .DEF_PERIOD(DEF)) dut_b (
    .SC_VEL_CLOCK_50(clk), .SC_VEL_RESET(rst), .run_in(run_b), .restart_in(restart_b),
    .lane_en_in(en_b), .level_in(level_b), .cfg_we_in(we_b), .cfg_lane_in(lane_b),
    .cfg_period_in(per_b), .tick_out(tick_b), .all_tick_out(all_b));

  int n_cmp = 0;
  int n_err = 0;

  // Reference: per lane, the programmed period and the number of enabled
  // cycles elapsed since the last tick / resync.
  int               m_per[LANES];
  int               m_elapsed[LANES];
  logic [LANES-1:0] m_tick;
  logic             m_all;

  function automatic int eff_of(int p, int lvl);
    int e = p >> lvl;
    if (p != 0 && e == 0) e = 1;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_per[i]     = DEF;
      m_elapsed[i] = 0;
    end
    m_tick = '0;
    m_all  = 1'b0;
  endtask

  task automatic model_step();
    logic [LANES-1:0] nt = '0;
    for (int i = 0; i < LANES; i++) begin
      int e   = eff_of(m_per[i], int'(level));
      bit hit = cfg_we && (int'(cfg_lane) == i);
      if (restart || hit) begin
        m_elapsed[i] = 0;
      end else if (run && en[i] && e > 0) begin
        m_elapsed[i] = m_elapsed[i] + 1;
        if (m_elapsed[i] >= e) begin
          nt[i]        = 1'b1;
          m_elapsed[i] = 0;
        end
      end
      if (hit) m_per[i] = int'(cfg_period);
    end
    m_tick = nt;
    m_all  = (en != '0) && ((nt | ~en) == '1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("tick", {28'd0, tick}, {28'd0, m_tick});
    check("all_tick", {31'd0, all_tick}, {31'd0, m_all});
  endtask

  task automatic write_cfg(input int lane, input int per);
    cfg_we     = 1'b1;
    cfg_lane   = lane[1:0];
    cfg_period = per[CW-1:0];
    cyc();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; restart = 1'b0; en = '0; level = '0;
    cfg_we = 1'b0; cfg_lane = '0; cfg_period = '0;
    run_b = 1'b0; restart_b = 1'b0; en_b = '0; level_b = '0;
    we_b = 1'b0; lane_b = '0; per_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tick", {28'd0, tick}, 32'd0);
    check("rst_all", {31'd0, all_tick}, 32'd0);
    check("rst_tick_b", {27'd0, tick_b}, 32'd0);
    rst = 1'b0;

    // Step 1: default period on all lanes
    run = 1'b1; en = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (c % 4 == 0) begin
        check("s1_tick", {28'd0, tick}, 32'hF);
        check("s1_all", {31'd0, all_tick}, 32'd1);
      end
    end

    // Step 2: lane 1 reprogrammed to 6 at cycle 2 after a restart
    restart = 1'b1; cyc(); restart = 1'b0;
    cyc();
    write_cfg(1, 6);
    for (int c = 3; c <= 16; c++) begin
      cyc();
      if (c == 8)  check("s2_all8", {31'd0, all_tick}, 32'd1);
      if (c == 12) check("s2_tick12", {28'd0, tick}, 32'hD);
      if (c == 14) check("s2_tick14", {28'd0, tick}, 32'h2);
    end

    // Step 3: period 8 with level 2, then level 7 clamps eff to 1
    for (int i = 0; i < LANES; i++) write_cfg(i, 8);
    level = 3'd2;
    restart = 1'b1; cyc(); restart = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      check("s3_lvl2", {28'd0, tick}, (c % 2 == 0) ? 32'hF : 32'h0);
    end
    level = 3'd7;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      check("s3_lvl7", {28'd0, tick}, 32'hF);
    end

    // Step 4: pause at cnt=2, resume
    level = 3'd0;
    for (int i = 0; i < LANES; i++) write_cfg(i, 4);
    restart = 1'b1; cyc(); restart = 1'b0;
    cyc(); cyc();
    run = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      check("s4_pause", {28'd0, tick}, 32'h0);
    end
    run = 1'b1;
    cyc();
    check("s4_res1", {28'd0, tick}, 32'h0);
    cyc();
    check("s4_res2", {28'd0, tick}, 32'hF);

    // Step 5: restart and write together, then a stopped lane
    restart = 1'b1; cfg_we = 1'b1; cfg_lane = 2'd2; cfg_period = 8'd6;
    cyc();
    restart = 1'b0; cfg_we = 1'b0;
    check("s5_rw_tick", {28'd0, tick}, 32'h0);
    write_cfg(3, 0);
    for (int c = 2; c <= 14; c++) begin
      cyc();
      if (c == 6)  check("s5_tick6", {28'd0, tick}, 32'h4);
      if (c == 12) check("s5_tick12", {28'd0, tick}, 32'h7);
      check("s5_stopped", {31'd0, tick[3]}, 32'd0);
    end
    en = 4'b0111;
    repeat (14) cyc();

    // Step 6: asynchronous reset mid-count after reprogramming
    write_cfg(0, 5);
    level = 3'd7;
    repeat (2) cyc();
    check("s6_pre", {28'd0, tick}, 32'h7);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("s6_rst_tick", {28'd0, tick}, 32'd0);
    check("s6_rst_all", {31'd0, all_tick}, 32'd0);
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    level = 3'd0; en = 4'hF; run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (c % 4 == 0) check("s6_def", {28'd0, tick}, 32'hF);
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      run     = ($urandom_range(0, 9) != 0);
      restart = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) en = LANES'($urandom);
      if ($urandom_range(0, 19) == 0)
        level = ($urandom_range(0, 5) == 0) ? 3'd7 : LW'($urandom_range(0, 3));
      cfg_we     = ($urandom_range(0, 9) == 0);
      cfg_lane   = 2'($urandom);
      cfg_period = CW'($urandom_range(0, 10));
      cyc();
    end
    cfg_we = 1'b0; restart = 1'b0;

    // Out-of-range lane writes on the five-lane instance
    we_b = 1'b1; lane_b = 3'd5; per_b = 8'd1;
    @(posedge clk); #1;
    lane_b = 3'd7;
    @(posedge clk); #1;
    we_b = 1'b0; run_b = 1'b1; en_b = 5'h1F;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      check("oor_tick", {27'd0, tick_b}, (c == 4) ? 32'h1F : 32'h0);
    end
    check("oor_all", {31'd0, all_b}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
